regfile_wb_arbiter: RTL

- Owns the single write port of the pipeline register file.
- Shares the port between the pipeline WB stage and a multi-cycle result unit (mult/div, slow load).
- Multi-cycle results are buffered in a small FIFO; a per-register scoreboard tells the hazard unit which registers have results still pending.
- After reset, sequences a zero-scrub of r1..r31 before normal operation.

---
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the pipeline/result unit and the register-file write arbiter.
// The slave modport is the arbiter's side.
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              wb_valid;
   logic [4:0]        wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              mc_req;
   logic [4:0]        mc_addr;
   logic [DATA_W-1:0] mc_data;
   logic              mc_ready;
   logic              mc_issue;
   logic [4:0]        mc_issue_addr;
   logic              rf_we;
   logic [4:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [31:0]       busy_mask;
   logic              wb_hold;
   logic              scrub_busy;

   modport master (
      output wb_valid, wb_addr, wb_data,
      output mc_req, mc_addr, mc_data, mc_issue, mc_issue_addr,
      input  mc_ready, rf_we, rf_waddr, rf_wdata, busy_mask, wb_hold, scrub_busy
   );

   modport slave (
      input  wb_valid, wb_addr, wb_data,
      input  mc_req, mc_addr, mc_data, mc_issue, mc_issue_addr,
      output mc_ready, rf_we, rf_waddr, rf_wdata, busy_mask, wb_hold, scrub_busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single register-file write port shared by the WB stage and a FIFO of multi-cycle
// results, with a pending-result scoreboard, starvation hold and post-reset zero-scrub.
module regfile_wb_arbiter #(
   parameter int DATA_W         = 32,
   parameter int FIFO_DEPTH     = 2,
   parameter int STARVE_LIMIT   = 4,
   parameter int SCRUB_ON_RESET = 1
) (
   input logic                 clk,
   input logic                 reset,
   regfile_wb_arbiter_if.slave bus
);
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {ST_SCRUB, ST_RUN} state_t;
   localparam state_t RESET_STATE = (SCRUB_ON_RESET != 0) ? ST_SCRUB : ST_RUN;

   state_t              state_reg, state_next;
   logic [4:0]          scrub_idx_reg, scrub_idx_next;
   logic                rf_we_reg, rf_we_next;
   logic [4:0]          rf_waddr_reg, rf_waddr_next;
   logic [DATA_W-1:0]   rf_wdata_reg, rf_wdata_next;
   logic [31:0]         busy_reg, busy_next;
   logic                hold_reg, hold_next;
   logic [STARVE_W-1:0] starve_reg, starve_next;
   logic                mc_ready_reg, mc_ready_next;
   logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]    count_reg, count_next;

   logic [4:0]          fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
   logic [4:0]          head_addr;
   logic [DATA_W-1:0]   head_data;
   logic                push, pop, blocked, issue_en;

   assign head_addr = fifo_addr[rd_ptr_reg];
   assign head_data = fifo_data[rd_ptr_reg];
   assign issue_en  = (state_reg == ST_RUN) && bus.mc_issue;
   assign blocked   = (state_reg == ST_RUN) && bus.wb_valid && (count_reg != '0);

   always_comb begin
      state_next     = state_reg;
      scrub_idx_next = scrub_idx_reg;
      rf_we_next     = 1'b0;
      rf_waddr_next  = rf_waddr_reg;
      rf_wdata_next  = rf_wdata_reg;
      push           = 1'b0;
      pop            = 1'b0;
      case (state_reg)
         ST_SCRUB: begin
            // Index wraps to 0 after r31; that cycle only hands over to RUN.
            if (scrub_idx_reg == 5'd0) begin
               state_next = ST_RUN;
            end else begin
               rf_we_next     = 1'b1;
               rf_waddr_next  = scrub_idx_reg;
               rf_wdata_next  = '0;
               scrub_idx_next = scrub_idx_reg + 5'd1;
            end
         end
         ST_RUN: begin
            push = bus.mc_req && mc_ready_reg;
            if (bus.wb_valid) begin
               rf_we_next    = (bus.wb_addr != 5'd0);
               rf_waddr_next = bus.wb_addr;
               rf_wdata_next = bus.wb_data;
            end else if (count_reg != '0) begin
               pop           = 1'b1;
               rf_we_next    = (head_addr != 5'd0);
               rf_waddr_next = head_addr;
               rf_wdata_next = head_data;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

   always_comb begin
      count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);
      mc_ready_next = (state_next == ST_RUN) && (count_next < CNT_W'(FIFO_DEPTH));
      starve_next   = starve_reg;
      hold_next     = hold_reg;
      if (pop) begin
         starve_next = '0;
         hold_next   = 1'b0;
      end else begin
         // Hold follows one edge after the counter has saturated at the limit.
         if (starve_reg == STARVE_W'(STARVE_LIMIT)) begin
            hold_next = 1'b1;
         end
         if (blocked && (starve_reg != STARVE_W'(STARVE_LIMIT))) begin
            starve_next = starve_reg + STARVE_W'(1);
         end
      end
   end

   // Issue sets a bit, the pop that writes the entry clears it; set wins on a tie.
   assign busy_next[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_busy
         assign busy_next[gi] = (issue_en && (bus.mc_issue_addr == 5'(gi))) ||
                                (busy_reg[gi] && !(pop && (head_addr == 5'(gi))));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= RESET_STATE;
         scrub_idx_reg <= 5'd1;
         rf_we_reg     <= 1'b0;
         rf_waddr_reg  <= 5'd0;
         rf_wdata_reg  <= '0;
         busy_reg      <= '0;
         hold_reg      <= 1'b0;
         starve_reg    <= '0;
         mc_ready_reg  <= 1'b0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         scrub_idx_reg <= scrub_idx_next;
         rf_we_reg     <= rf_we_next;
         rf_waddr_reg  <= rf_waddr_next;
         rf_wdata_reg  <= rf_wdata_next;
         busy_reg      <= busy_next;
         hold_reg      <= hold_next;
         starve_reg    <= starve_next;
         mc_ready_reg  <= mc_ready_next;
         count_reg     <= count_next;
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr_reg] <= bus.mc_addr;
         fifo_data[wr_ptr_reg] <= bus.mc_data;
      end
   end

   assign bus.rf_we      = rf_we_reg;
   assign bus.rf_waddr   = rf_waddr_reg;
   assign bus.rf_wdata   = rf_wdata_reg;
   assign bus.busy_mask  = busy_reg;
   assign bus.wb_hold    = hold_reg;
   assign bus.mc_ready   = mc_ready_reg;
   assign bus.scrub_busy = (state_reg == ST_SCRUB);
endmodule
